// File: rtl/pc_pkg.sv
// Shared types for the fetch PC predictor: BTB entry layout and
// 2-bit saturating direction counter helpers.
package pc_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;

   // Widest supported address; narrower configurations zero-extend into it.
   localparam int PC_MAX_W = 64;

   typedef struct packed {
      logic                valid;
      logic [PC_MAX_W-1:0] tag;
      logic [PC_MAX_W-1:0] target;
      ctr_t                ctr;
   } btb_entry_t;

   function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
      ctr_t res;
      if (taken) begin
         res = (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
      end else begin
         res = (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
      end
      return res;
   endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// training from resolved branches, and a whole-table flush.
module pc_btb
   import pc_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            flush,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   logic [XLEN-1:0]        target_q [BTB_ENTRIES];
   ctr_t                   ctr_q    [BTB_ENTRIES];

   logic [IDX-1:0]   rd_idx, up_idx;
   logic [TAG_W-1:0] rd_tag, up_tag;
   logic             up_hit;
   logic [XLEN-1:0]  up_target_al;
   btb_entry_t       rd_entry;
   logic             unused_bits;

   assign rd_idx       = pc[IDX+1:2];
   assign rd_tag       = pc[XLEN-1:IDX+2];
   assign up_idx       = upd_pc[IDX+1:2];
   assign up_tag       = upd_pc[XLEN-1:IDX+2];
   assign up_target_al = {upd_target[XLEN-1:2], 2'b00};
   assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_comb begin
      rd_entry.valid  = valid_q[rd_idx];
      rd_entry.tag    = PC_MAX_W'(tag_q[rd_idx]);
      rd_entry.target = PC_MAX_W'(target_q[rd_idx]);
      rd_entry.ctr    = ctr_q[rd_idx];
   end

   assign pred_taken  = rd_entry.valid && (rd_entry.tag == PC_MAX_W'(rd_tag)) && rd_entry.ctr[1];
   assign pred_target = rd_entry.target[XLEN-1:0];

   // Zero-extension padding and the byte-offset bits never influence a result.
   assign unused_bits = ^{rd_entry, pc[1:0], upd_pc[1:0], upd_target[1:0]};

   // Only the valid bits need a defined reset; a flush beats any allocation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (upd_valid && !up_hit && upd_taken) begin
         valid_q[up_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (upd_valid && !flush) begin
         if (up_hit) begin
            ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken);
            if (upd_taken) begin
               target_q[up_idx] <= up_target_al;
            end
         end else if (upd_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= up_target_al;
            ctr_q[up_idx]    <= CTR_WT;
         end
      end
   end

endmodule

// File: rtl/pc_predict.sv
// Fetch program counter with redirect priority and stall hold. The BTB
// predictor is built only when PC_PREDICT_BTB_EN is defined.
module pc_predict
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BTB_ENTRIES  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_target,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            btb_flush,
   output logic [XLEN-1:0] pc_out,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_next;
   logic            unused_lo;

   assign pc_out    = pc_q;
   assign unused_lo = ^{trap_target[1:0], redirect_target[1:0]};

`ifdef PC_PREDICT_BTB_EN
   pc_btb #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc_q),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_taken   (upd_taken),
      .flush       (btb_flush),
      .pred_taken  (pred_taken),
      .pred_target (pred_target)
   );
`else
   logic unused_upd;

   assign pred_taken  = 1'b0;
   assign pred_target = '0;
   assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken, btb_flush};
`endif

   // Redirects override stall; the prediction only matters on a free-running cycle.
   always_comb begin
      pc_next = pc_q + XLEN'(4);
      if (trap_valid) begin
         pc_next = {trap_target[XLEN-1:2], 2'b00};
      end else if (redirect_valid) begin
         pc_next = {redirect_target[XLEN-1:2], 2'b00};
      end else if (stall) begin
         pc_next = pc_q;
      end else if (pred_taken) begin
         pc_next = pred_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_next;
      end
   end

endmodule

// File: tb/tb_pc_predict.sv
// Scoreboard bench for pc_predict: the driver queues the expected post-edge
// outputs, a monitor pops and compares them one step after each rising edge.
module tb_pc_predict;

`ifdef PC_PREDICT_BTB_EN
   localparam bit BTB_ON = 1'b1;
`else
   localparam bit BTB_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall, trap_valid, redirect_valid, upd_valid, upd_taken, btb_flush;
   logic [31:0] trap_target, redirect_target, upd_pc, upd_target;
   logic [31:0] pc_out, pred_target;
   logic        pred_taken;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tg;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   pc_predict #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .BTB_ENTRIES  (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .trap_valid      (trap_valid),
      .trap_target     (trap_target),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_target      (upd_target),
      .upd_taken       (upd_taken),
      .btb_flush       (btb_flush),
      .pc_out          (pc_out),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target)
   );

   always #5 clk = ~clk;

   task automatic idle();
      stall = 0; trap_valid = 0; trap_target = 0; redirect_valid = 0; redirect_target = 0;
      upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; btb_flush = 0;
   endtask

   task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
      upd_valid = 1; upd_pc = p; upd_target = t; upd_taken = tk;
   endtask

   task automatic redir(input logic [31:0] t);
      redirect_valid = 1; redirect_target = t;
   endtask

   task automatic expect_out(input logic [31:0] pc, input logic pt, input logic [31:0] tg,
                             input string nm);
      exp_t e;
      e.pc = pc; e.pt = pt; e.tg = tg; e.name = nm;
      sbq.push_back(e);
   endtask

   task automatic check(input exp_t e);
      n_vec++;
      if (pc_out !== e.pc || pred_taken !== e.pt || (e.pt && pred_target !== e.tg)) begin
         n_bad++;
         $display("FAIL %s: got pc=%h pt=%b tgt=%h, want pc=%h pt=%b tgt=%h",
                  e.name, pc_out, pred_taken, pred_target, e.pc, e.pt, e.tg);
      end
   endtask

   // Monitor: one expected record per rising edge, sampled 1 time unit later.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) check(sbq.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      exp_t d;
      idle();
      #1 rst_n = 0;
      #1;
      d.pc = 32'h0; d.pt = 0; d.tg = 0; d.name = "reset_async";
      check(d);

      @(negedge clk); rst_n = 1; idle();       expect_out(32'h4, 0, 0, "seq_4");
      @(negedge clk); idle();                  expect_out(32'h8, 0, 0, "seq_8");
      @(negedge clk); idle();                  expect_out(32'hC, 0, 0, "seq_c");
      @(negedge clk); idle(); trap_valid = 1; trap_target = 32'h100; redir(32'h200); stall = 1;
      expect_out(32'h100, 0, 0, "prio_trap");
      @(negedge clk); idle(); redir(32'h200); stall = 1;
      expect_out(32'h200, 0, 0, "prio_redirect");
      @(negedge clk); idle(); stall = 1;       expect_out(32'h200, 0, 0, "stall_hold");
      @(negedge clk); idle(); redir(32'hFFFF_FFFF);
      expect_out(32'hFFFF_FFFC, 0, 0, "target_align");
      @(negedge clk); idle();                  expect_out(32'h0, 0, 0, "wrap");

      // Training 0x10 -> 0x80 while fetching sequentially from 0
      @(negedge clk); idle(); upd(32'h10, 32'h80, 1); expect_out(32'h4, 0, 0, "train1");
      @(negedge clk); idle(); upd(32'h10, 32'h80, 1); expect_out(32'h8, 0, 0, "train2");
      @(negedge clk); idle();                  expect_out(32'hC, 0, 0, "pre_hit");
      @(negedge clk); idle();                  expect_out(32'h10, BTB_ON, 32'h80, "hit_pred");
      @(negedge clk); idle();
      expect_out(BTB_ON ? 32'h80 : 32'h14, 0, 0, "follow_pred");

      // Two not-taken updates: strong-T -> weak-T -> weak-NT
      @(negedge clk); idle(); redir(32'h10); upd(32'h10, 32'h0, 0);
      expect_out(32'h10, BTB_ON, 32'h80, "nt1_still_taken");
      @(negedge clk); idle(); stall = 1; upd(32'h10, 32'h0, 0);
      expect_out(32'h10, 0, 0, "nt2_not_taken");
      @(negedge clk); idle();                  expect_out(32'h14, 0, 0, "nt_fallthrough");

      // Aliasing: 0x50 shares the index of 0x10 with a different tag
      @(negedge clk); idle(); stall = 1; upd(32'h10, 32'h80, 1);
      expect_out(32'h14, 0, 0, "retrain");
      @(negedge clk); idle(); redir(32'h50);   expect_out(32'h50, 0, 0, "alias_miss");
      @(negedge clk); idle(); stall = 1; upd(32'h50, 32'h999, 0);
      expect_out(32'h50, 0, 0, "miss_nt_noop");
      @(negedge clk); idle(); redir(32'h10);   expect_out(32'h10, BTB_ON, 32'h80, "entry_intact");
      @(negedge clk); idle(); stall = 1; upd(32'h10, 32'h123, 1);
      expect_out(32'h10, BTB_ON, 32'h120, "target_overwrite");
      @(negedge clk); idle();
      expect_out(BTB_ON ? 32'h120 : 32'h14, 0, 0, "follow_new_target");

      // Flush collides with a taken update: flush wins
      @(negedge clk); idle(); redir(32'h10); btb_flush = 1; upd(32'h10, 32'h80, 1);
      expect_out(32'h10, 0, 0, "flush_collision");
      @(negedge clk); idle();                  expect_out(32'h14, 0, 0, "after_flush");

      // Reset mid-run while fetching 0x40 with a live prediction
      @(negedge clk); idle(); redir(32'h40);   expect_out(32'h40, 0, 0, "goto_40");
      @(negedge clk); idle(); stall = 1; upd(32'h40, 32'h200, 1);
      expect_out(32'h40, BTB_ON, 32'h200, "train_40");
      @(negedge clk); idle(); rst_n = 0;
      #1;
      d.pc = 32'h0; d.pt = 0; d.tg = 0; d.name = "reset_midrun";
      check(d);
      expect_out(32'h0, 0, 0, "reset_hold");
      @(negedge clk); rst_n = 1; idle();       expect_out(32'h4, 0, 0, "reset_release");
      @(negedge clk); idle(); redir(32'h40);   expect_out(32'h40, 0, 0, "btb_cleared_by_reset");

      @(negedge clk); idle();
      repeat (3) @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending records, want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
